// File: rtl/pcx_core_arb_if.sv
`default_nettype none
// ============================================================================
// Module : pcx_core_arb_if
// Brief  : Two-core PCX ingress and shared CCX-bridge link signals.
// Rev    : 1.0
// ============================================================================
interface pcx_core_arb_if #(
    parameter int PCX_WIDTH = 124
);
    logic [4:0]           c0_req_pq;
    logic [4:0]           c1_req_pq;
    logic                 c0_atom_pq;
    logic                 c1_atom_pq;
    logic [PCX_WIDTH-1:0] c0_data_pa;
    logic [PCX_WIDTH-1:0] c1_data_pa;
    logic [4:0]           c0_grant_px;
    logic [4:0]           c1_grant_px;
    logic [4:0]           m_req_pq;
    logic                 m_atom_pq;
    logic [PCX_WIDTH-1:0] m_data_pa;
    logic [4:0]           m_grant_px;
    logic [1:0]           ovf_err;
    logic                 busy;

    // Arbiter side
    modport slave (
        input  c0_req_pq, c1_req_pq, c0_atom_pq, c1_atom_pq,
        input  c0_data_pa, c1_data_pa, m_grant_px,
        output c0_grant_px, c1_grant_px, m_req_pq, m_atom_pq, m_data_pa,
        output ovf_err, busy
    );

    // Cores and bridge side
    modport master (
        output c0_req_pq, c1_req_pq, c0_atom_pq, c1_atom_pq,
        output c0_data_pa, c1_data_pa, m_grant_px,
        input  c0_grant_px, c1_grant_px, m_req_pq, m_atom_pq, m_data_pa,
        input  ovf_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/pcx_core_arb.sv
`default_nettype none
// ============================================================================
// Module : pcx_core_arb
// Brief  : Round-robin arbiter of two cores' PCX packets onto one bridge link,
//          with per-core FIFOs and atomic-pair locking.
// Rev    : 1.0
// ============================================================================
module pcx_core_arb #(
    parameter int PCX_WIDTH  = 124,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic     gclk,
    input  wire logic     reset_l,
    pcx_core_arb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PCX_WIDTH + 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_LOCK = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic                      r_owner;
    logic                      r_last;
    logic                      r_second;
    logic [1:0][4:0]           r_grant;

    logic [1:0][4:0]           w_req;
    logic [1:0]                w_atom_in;
    logic [1:0][PCX_WIDTH-1:0] w_data_in;
    logic [1:0]                w_empty;
    logic [1:0]                w_pop;
    logic [1:0]                w_ovf;
    logic [1:0][EW-1:0]        w_head;
    logic [EW-1:0]             w_own_head;
    logic                      w_granted;
    logic                      w_sel;

    assign w_req     = {bus.c1_req_pq, bus.c0_req_pq};
    assign w_atom_in = {bus.c1_atom_pq, bus.c0_atom_pq};
    assign w_data_in = {bus.c1_data_pa, bus.c0_data_pa};

    genvar g;
    generate
        for (g = 0; g < 2; g = g + 1) begin : g_core
            logic          r_pend;
            logic [4:0]    r_dest;
            logic          r_atom;
            logic [AW:0]   r_wr;
            logic [AW:0]   r_rd;
            logic          r_ovf;
            logic [EW-1:0] r_mem [FIFO_DEPTH];
            logic          w_full;
            logic          w_push;

            assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts
            assign w_push     = r_pend && (!w_full || w_pop[g]);
            assign w_empty[g] = (r_wr == r_rd);
            assign w_head[g]  = r_mem[r_rd[AW-1:0]];
            assign w_ovf[g]   = r_ovf;

            always_ff @(posedge gclk or negedge reset_l) begin
                if (!reset_l) begin
                    r_pend <= 1'b0;
                    r_dest <= 5'd0;
                    r_atom <= 1'b0;
                    r_wr   <= '0;
                    r_rd   <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    r_pend <= (w_req[g] != 5'd0);
                    r_dest <= w_req[g];
                    r_atom <= w_atom_in[g];
                    if (w_push)
                        r_wr <= r_wr + (AW+1)'(1);
                    if (w_pop[g])
                        r_rd <= r_rd + (AW+1)'(1);
                    if (r_pend && !w_push)
                        r_ovf <= 1'b1;
                end
            end

            always_ff @(posedge gclk) begin
                if (w_push)
                    r_mem[r_wr[AW-1:0]] <= {r_atom, r_dest, w_data_in[g]};
            end
        end
    endgenerate

    assign w_own_head = w_head[r_owner];
    assign w_granted  = (r_state == S_WAIT) && (bus.m_grant_px != 5'd0);
    // Both pending: the core after last_owner; otherwise whichever has data
    assign w_sel      = (!w_empty[0] && !w_empty[1]) ? ~r_last : w_empty[0];

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_second <= 1'b0;
            r_grant  <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= '0;
            if (r_state == S_IDLE && w_next == S_REQ)
                r_owner <= w_sel;
            if (w_granted) begin
                r_grant[r_owner] <= w_own_head[PCX_WIDTH +: 5];
                if (w_next == S_LOCK) begin
                    r_second <= 1'b1;
                end else begin
                    r_second <= 1'b0;
                    r_last   <= r_owner;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_empty != 2'b11) w_next = S_REQ;
            S_REQ:   w_next = S_DATA;
            S_DATA:  w_next = S_WAIT;
            S_WAIT:  if (w_granted)
                         w_next = (w_own_head[EW-1] && !r_second) ? S_LOCK : S_IDLE;
            S_LOCK:  if (!w_empty[r_owner]) w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.m_req_pq  = 5'd0;
        bus.m_atom_pq = 1'b0;
        bus.m_data_pa = '0;
        w_pop         = 2'b00;
        case (r_state)
            S_REQ: begin
                bus.m_req_pq  = w_own_head[PCX_WIDTH +: 5];
                bus.m_atom_pq = w_own_head[EW-1];
            end
            S_DATA:  bus.m_data_pa = w_own_head[PCX_WIDTH-1:0];
            S_WAIT:  w_pop[r_owner] = w_granted;
            default: ;
        endcase
    end

    assign bus.c0_grant_px = r_grant[0];
    assign bus.c1_grant_px = r_grant[1];
    assign bus.ovf_err     = w_ovf;
    assign bus.busy        = (r_state != S_IDLE) || (w_empty != 2'b11);

endmodule
`default_nettype wire

// File: tb/tb_pcx_core_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_pcx_core_arb
// Brief  : Self-checking bench for pcx_core_arb against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_pcx_core_arb;
    localparam int PW    = 124;
    localparam int DEPTH = 2;
    localparam int EW    = PW + 6;
    localparam int OW    = 5 + 5 + 5 + 1 + PW + 2 + 1;

    typedef logic [EW-1:0] ent_t;

    logic gclk    = 1'b0;
    logic reset_l = 1'b1;
    always #5 gclk = ~gclk;

    pcx_core_arb_if #(.PCX_WIDTH(PW)) bus ();
    pcx_core_arb #(.PCX_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .gclk   (gclk),
        .reset_l(reset_l),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: packet queues per core plus a link scheduler
    ent_t       mq [2][$];
    bit         m_active;
    bit         m_second;
    int         m_owner;
    int         m_req_cyc;
    int         m_free;
    int         m_lock;
    int         m_last;
    int         cyc = 0;
    logic [1:0] m_pend;
    logic [4:0] m_pdest [2];
    logic       m_patom [2];
    logic [4:0] m_gnt [2];
    logic [1:0] m_ovf;

    logic [OW-1:0] exp_vec;
    logic [OW-1:0] obs_vec;
    assign obs_vec = {bus.c0_grant_px, bus.c1_grant_px, bus.m_req_pq, bus.m_atom_pq,
                      bus.m_data_pa, bus.ovf_err, bus.busy};

    function automatic logic [PW-1:0] rand_data();
        logic [127:0] x;
        x = {$urandom, $urandom, $urandom, $urandom};
        return x[PW-1:0];
    endfunction

    function automatic logic [4:0] rand_req(input int pct);
        logic [4:0] r;
        r = 5'd0;
        if ($urandom_range(0, 99) < pct) r = 5'b00001 << $urandom_range(0, 4);
        return r;
    endfunction

    function automatic void model_reset();
        mq[0].delete();
        mq[1].delete();
        m_active = 0; m_second = 0; m_owner = 0; m_req_cyc = 0;
        m_free = 0; m_lock = -1; m_last = 1;
        m_pend = 2'b00; m_ovf = 2'b00;
        m_gnt[0] = 5'd0; m_gnt[1] = 5'd0;
    endfunction

    function automatic void start_pkt(input int o, input bit second);
        m_active  = 1;
        m_owner   = o;
        m_second  = second;
        m_req_cyc = cyc + 1;
    endfunction

    function automatic void predict();
        ent_t          h  = '0;
        logic [4:0]    rq = 5'd0;
        logic          at = 1'b0;
        logic [PW-1:0] dt = '0;
        logic          bz;
        if (m_active) h = mq[m_owner][0];
        if (m_active && cyc == m_req_cyc) begin
            rq = h[PW +: 5];
            at = h[EW-1];
        end
        if (m_active && cyc == m_req_cyc + 1) dt = h[PW-1:0];
        bz = m_active || (m_lock >= 0) || (mq[0].size() != 0) || (mq[1].size() != 0);
        exp_vec = {m_gnt[0], m_gnt[1], rq, at, dt, m_ovf, bz};
    endfunction

    function automatic void update(input logic [1:0][4:0] rq, input logic [1:0] at,
                                   input logic [1:0][PW-1:0] dt, input logic [4:0] mg);
        ent_t e;
        m_gnt[0] = 5'd0;
        m_gnt[1] = 5'd0;
        if (m_active && cyc >= m_req_cyc + 2 && mg != 5'd0) begin
            e = mq[m_owner].pop_front();
            m_gnt[m_owner] = e[PW +: 5];
            m_active = 0;
            m_free   = cyc + 1;
            if (m_second) begin
                m_lock = -1;
                m_last = m_owner;
            end else if (e[EW-1]) begin
                m_lock = m_owner;
            end else begin
                m_last = m_owner;
            end
        end else if (!m_active && cyc >= m_free) begin
            if (m_lock >= 0) begin
                if (mq[m_lock].size() != 0) start_pkt(m_lock, 1);
            end else if (mq[0].size() != 0 && mq[1].size() != 0) start_pkt(1 - m_last, 0);
            else if (mq[0].size() != 0) start_pkt(0, 0);
            else if (mq[1].size() != 0) start_pkt(1, 0);
        end
        for (int c = 0; c < 2; c++) begin
            if (m_pend[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back({m_patom[c], m_pdest[c], dt[c]});
                else m_ovf[c] = 1'b1;
            end
            m_pend[c]  = (rq[c] != 5'd0);
            m_pdest[c] = rq[c];
            m_patom[c] = at[c];
        end
        cyc++;
    endfunction

    task automatic zero_inputs();
        bus.c0_req_pq = 5'd0; bus.c0_atom_pq = 1'b0; bus.c0_data_pa = '0;
        bus.c1_req_pq = 5'd0; bus.c1_atom_pq = 1'b0; bus.c1_data_pa = '0;
        bus.m_grant_px = 5'd0;
    endtask

    task automatic tick(input logic [4:0] r0, input logic a0, input logic [PW-1:0] d0,
                        input logic [4:0] r1, input logic a1, input logic [PW-1:0] d1,
                        input logic [4:0] mg);
        @(posedge gclk);
        #1;
        bus.c0_req_pq = r0; bus.c0_atom_pq = a0; bus.c0_data_pa = d0;
        bus.c1_req_pq = r1; bus.c1_atom_pq = a1; bus.c1_data_pa = d1;
        bus.m_grant_px = mg;
        predict();
        @(negedge gclk);
        update({r1, r0}, {a1, a0}, {d1, d0}, mg);
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        zero_inputs();
        model_reset();
        repeat (3) @(posedge gclk);
        #1 reset_l = 1'b1;
    endtask

    task automatic test_reset();
        zero_inputs();
        #2 reset_l = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec !== '0) $display("FAIL reset_outputs got=%h exp=0", obs_vec);
        else n_pass++;
        repeat (2) @(posedge gclk);
        #1 reset_l = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(5'd0, 1'b0, rand_data(), 5'd0, 1'b0, rand_data(), 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick((k == 0) ? 5'b00001 : 5'd0, 1'b0, (k == 1) ? 124'hA5 : rand_data(),
                 5'd0, 1'b0, rand_data(), (k == 6) ? 5'b00001 : 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL single_lockstep k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (bus.m_req_pq !== 5'b00001) $display("FAIL single_mreq got=%b exp=00001", bus.m_req_pq);
                else n_pass++;
            end
            if (k == 4) begin
                n_checks++;
                if (bus.m_data_pa !== 124'hA5) $display("FAIL single_mdata got=%h exp=a5", bus.m_data_pa);
                else n_pass++;
            end
            n_checks++;
            if (bus.c0_grant_px !== ((k == 7) ? 5'b00001 : 5'd0))
                $display("FAIL single_grant k=%0d got=%b exp=%b", k, bus.c0_grant_px, (k == 7) ? 5'b00001 : 5'd0);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int want[4] = '{0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick((k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd0, 1'b0, rand_data(),
                 (k == 0) ? 5'd4 : (k == 1) ? 5'd8 : 5'd0, 1'b0, rand_data(), 5'd1);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rr_lockstep k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
            if (bus.c0_grant_px != 5'd0) order.push_back(0);
            if (bus.c1_grant_px != 5'd0) order.push_back(1);
        end
        n_checks++;
        if (order.size() != 4) $display("FAIL rr_count got=%0d exp=4", order.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            n_checks++;
            if (order[i] != want[i]) $display("FAIL rr_order idx=%0d got=c%0d exp=c%0d", i, order[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_atomic(input int gap);
        int order[$];
        int want[3] = '{1, 1, 0};
        do_reset();
        for (int k = 0; k < 45; k++) begin
            tick((k == 1) ? 5'd1 : 5'd0, 1'b0, rand_data(),
                 (k == 0) ? 5'd2 : (k == gap) ? 5'd4 : 5'd0,
                 (k == 0) || (k == gap && gap == 8), rand_data(), 5'd1);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL atomic_lockstep gap=%0d k=%0d got=%h exp=%h", gap, k, obs_vec, exp_vec);
            else n_pass++;
            if (gap == 8 && k >= 7 && k <= 10) begin
                n_checks++;
                if (bus.m_req_pq !== 5'd0 || bus.busy !== 1'b1)
                    $display("FAIL atomic_lock_hold k=%0d got req=%b busy=%b exp req=0 busy=1", k, bus.m_req_pq, bus.busy);
                else n_pass++;
            end
            if (bus.c0_grant_px != 5'd0) order.push_back(0);
            if (bus.c1_grant_px != 5'd0) order.push_back(1);
        end
        n_checks++;
        if (order.size() != 3) $display("FAIL atomic_count gap=%0d got=%0d exp=3", gap, order.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < order.size(); i++) begin
            n_checks++;
            if (order[i] != want[i]) $display("FAIL atomic_order gap=%0d idx=%0d got=c%0d exp=c%0d", gap, i, order[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [4:0] gl[$];
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick((k == 0) ? 5'd1 : (k == 1) ? 5'd2 : (k == 2) ? 5'd4 : 5'd0, 1'b0, rand_data(),
                 5'd0, 1'b0, rand_data(), (k >= 20) ? 5'd1 : 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL ovf_lockstep k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
            if (k == 19 || k == 49) begin
                n_checks++;
                if (bus.ovf_err !== 2'b01) $display("FAIL ovf_flag k=%0d got=%b exp=01", k, bus.ovf_err);
                else n_pass++;
            end
            if (bus.c0_grant_px != 5'd0) gl.push_back(bus.c0_grant_px);
        end
        n_checks++;
        if (gl.size() != 2) $display("FAIL ovf_grants got=%0d exp=2", gl.size());
        else n_pass++;
        if (gl.size() == 2) begin
            n_checks++;
            if (gl[0] !== 5'd1 || gl[1] !== 5'd2) $display("FAIL ovf_dests got=%b,%b exp=00001,00010", gl[0], gl[1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick((k == 0) ? 5'd8 : 5'd0, 1'b0, rand_data(), 5'd0, 1'b0, rand_data(), 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rstwait_lockstep k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
        end
        @(posedge gclk);
        #3 reset_l = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== '0) $display("FAIL rstwait_outputs got=%h exp=0", obs_vec);
        else n_pass++;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge gclk);
        #1 reset_l = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(5'd0, 1'b0, rand_data(), 5'd0, 1'b0, rand_data(), 5'd8);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rstwait_after k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (bus.c0_grant_px !== 5'd0 || bus.busy !== 1'b0)
                $display("FAIL rstwait_nogrant k=%0d got grant=%b busy=%b exp grant=0 busy=0", k, bus.c0_grant_px, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_stray_grant();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(5'd0, 1'b0, rand_data(), 5'd0, 1'b0, rand_data(), 5'($urandom_range(1, 31)));
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL stray_lockstep k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (bus.c0_grant_px !== 5'd0 || bus.c1_grant_px !== 5'd0 || bus.busy !== 1'b0)
                $display("FAIL stray_idle k=%0d got g0=%b g1=%b busy=%b exp 0", k, bus.c0_grant_px, bus.c1_grant_px, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            tick(rand_req(30), ($urandom_range(0, 3) == 0), rand_data(),
                 rand_req(30), ($urandom_range(0, 3) == 0), rand_data(),
                 ($urandom_range(0, 99) < 35) ? 5'($urandom_range(1, 31)) : 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL random_lockstep i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_atomic(3);
        test_atomic(8);
        test_overflow();
        test_reset_in_wait();
        test_stray_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
